// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: registered seven-segment decoder with a time-multiplexed
// digit scan. A small register bank holds one nibble per digit, a prescaler
// sets the scan rate, and a single shared segment bus is driven together with
// a one-hot digit enable. Decode supports hex and BCD (dash for 10..15).
module seg_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int AW         = $clog2(NUM_DIGITS),
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    output logic                  wr_err,
    input  logic                  mode,
    input  logic [NUM_DIGITS-1:0] blank,
    input  logic [DIV_WIDTH-1:0]  div_load,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  scan_tick
);

    // Pointer width covers exactly the digit indices; wr_addr may be wider so
    // that out-of-range writes can be presented and rejected.
    localparam int PW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0]         PTR_ONE    = PW'(1'b1);
    localparam logic [PW-1:0]         PTR_LAST   = PW'(NUM_DIGITS - 1);
    localparam logic [DIV_WIDTH-1:0]  CNT_ONE    = DIV_WIDTH'(1'b1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1'b1);
    localparam logic [AW:0]           ADDR_LIMIT = (AW + 1)'(NUM_DIGITS);

    // Hex nibble to {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // BCD mode shows a dash (segment g only) for non-decimal nibbles.
    function automatic logic [6:0] decode_seg(input logic [3:0] nib, input logic bcd);
        logic [6:0] seg;
        if (bcd && (nib > 4'd9)) begin
            seg = 7'h40;
        end else begin
            seg = decode_hex(nib);
        end
        return seg;
    endfunction

    logic [3:0]            r_digit [NUM_DIGITS];
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [PW-1:0]         r_ptr;
    logic                  r_tick_d;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig_en;
    logic                  r_scan_tick;
    logic                  r_wr_err;

    logic                  w_tick;
    logic                  w_wr_ok;
    logic                  w_wr_bad;
    logic [3:0]            w_cur_nib;
    logic                  w_cur_blank;
    logic [6:0]            w_seg_next;
    logic [NUM_DIGITS-1:0] w_dig_next;

    // Tick, write qualification and next output values from pre-edge state.
    always_comb begin
        w_tick      = 1'b0;
        w_wr_ok     = 1'b0;
        w_wr_bad    = 1'b0;
        w_cur_nib   = r_digit[r_ptr];
        w_cur_blank = blank[r_ptr];
        w_seg_next  = 7'h00;
        w_dig_next  = {NUM_DIGITS{1'b0}};

        // >= rather than == so a lowered div_load never forces a full wrap.
        if (r_cnt >= div_load) begin
            w_tick = 1'b1;
        end else begin
            w_tick = 1'b0;
        end

        if (wr_en) begin
            if ({1'b0, wr_addr} < ADDR_LIMIT) begin
                w_wr_ok  = 1'b1;
                w_wr_bad = 1'b0;
            end else begin
                w_wr_ok  = 1'b0;
                w_wr_bad = 1'b1;
            end
        end else begin
            w_wr_ok  = 1'b0;
            w_wr_bad = 1'b0;
        end

        if (w_cur_blank) begin
            w_seg_next = 7'h00;
            w_dig_next = {NUM_DIGITS{1'b0}};
        end else begin
            w_seg_next = decode_seg(w_cur_nib, mode);
            w_dig_next = DIG_ONE << r_ptr;
        end
    end

    // Per-digit value bank; only in-range writes land.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digit[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_wr_ok && (wr_addr == AW'(i))) begin
                    r_digit[i] <= wr_data;
                end
            end
        end
    end

    // Scan prescaler and digit pointer; pointer moves on the tick edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= {DIV_WIDTH{1'b0}};
            r_ptr    <= {PW{1'b0}};
            r_tick_d <= 1'b0;
        end else begin
            r_tick_d <= w_tick;
            if (w_tick) begin
                r_cnt <= {DIV_WIDTH{1'b0}};
                if (r_ptr == PTR_LAST) begin
                    r_ptr <= {PW{1'b0}};
                end else begin
                    r_ptr <= r_ptr + PTR_ONE;
                end
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    // Output register: segments, digit enable, scan pulse aligned with the
    // first cycle a new digit is shown, and the dropped-write flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_seg       <= 7'h00;
            r_dig_en    <= {NUM_DIGITS{1'b0}};
            r_scan_tick <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_seg       <= w_seg_next;
            r_dig_en    <= w_dig_next;
            r_scan_tick <= r_tick_d;
            r_wr_err    <= w_wr_bad;
        end
    end

    assign seg_out   = r_seg;
    assign dig_en    = r_dig_en;
    assign scan_tick = r_scan_tick;
    assign wr_err    = r_wr_err;

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Parametrised, registered seven-segment decoder with a time-multiplexed scan that drives NUM_DIGITS digits from one shared segment bus. It is the next generation of the single-input combinational decoder project. It adds a per-digit value register bank, hex/BCD decode modes, per-digit blanking and a programmable scan prescaler. The block sits between the user-project input pins (write port) and the display output pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..16)
- AW, $clog2(NUM_DIGITS), width of wr_addr
- DIV_WIDTH, 16, prescaler width
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe, sampled every rising edge
- wr_addr  in  AW  target digit index
- wr_data  in  4  nibble to store
- wr_err  out  1  one-cycle pulse: write to an address >= NUM_DIGITS was dropped
- mode  in  1  0 = hex decode, 1 = BCD decode
- blank  in  NUM_DIGITS  per-digit blank mask, 1 = blank
- div_load  in  DIV_WIDTH  scan terminal count; scan period = div_load+1 cycles
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-high, registered
- dig_en  out  NUM_DIGITS  one-hot digit enable, active-high, registered
- scan_tick  out  1  registered pulse, high for one cycle per pointer advance

## Operation
- Storage: digit_reg[NUM_DIGITS] x 4 bits.
  - When wr_en=1 and wr_addr<NUM_DIGITS, digit_reg[wr_addr] takes wr_data at the edge.
  - When wr_en=1 and wr_addr>=NUM_DIGITS, storage is unchanged and wr_err=1 for the next cycle.
- Prescaler: cnt (DIV_WIDTH bits).
  - If cnt >= div_load: cnt <= 0 and tick is asserted.
  - Otherwise: cnt <= cnt+1.
  - The compare is >=, so lowering div_load mid-count never causes a 2^DIV_WIDTH overshoot.
  - div_load=0 gives a tick every cycle.
- Scan pointer ptr: advances on tick and wraps from NUM_DIGITS-1 to 0.
- Hex decode (nibble 0..F) → 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- BCD mode: nibbles 0..9 decode as hex; nibbles 10..15 → 0x40 (dash, segment g only).
- Output register, every cycle, using the value of ptr before the edge:
  - If blank[ptr]=1: seg_out <= 0 and dig_en <= 0.
  - Otherwise: seg_out <= decode(digit_reg[ptr], mode) and dig_en <= (1<<ptr).
- mode and blank are not registered on input. A change affects seg_out on the next edge.
- Write and tick on the same edge: both take effect. Storage and ptr update independently.

## Timing
- Reset values (asynchronous, immediate on reset_n low):
  - digit_reg all 0; cnt=0; ptr=0
  - seg_out=0; dig_en=0; scan_tick=0; wr_err=0
- First edge after reset release:
  - dig_en=0001 and seg_out=0x3F (digit 0 holding 0), unless blank[0].
- Write latency: data written at edge k to the digit ptr currently selects appears on seg_out after edge k+1.
- Scan latency: tick is raised internally at edge k, so ptr changes at edge k.
  - scan_tick=1 and dig_en/seg_out show the new digit after edge k+1.
  - The output register samples the pre-edge ptr, so the new digit appears one edge after ptr changes.
- Steady-state period: dig_en holds each digit for exactly div_load+1 cycles. scan_tick has the same period.
- Reset asserted mid-scan returns all state to the reset values within the same cycle. The scan restarts at digit 0.

## Test plan
- Reset: hold reset_n=0 with random inputs → all outputs 0. Release with div_load=3 → dig_en=0001 and seg_out=0x3F, then dig_en rotates 0001→0010→0100→1000→0001 every 4 cycles.
- Hex write/readback: write 0..F to digit 1, mode=0, div_load=0 → on every cycle with dig_en=0010, seg_out matches the full hex table.
- BCD mode: digit 2=0xB, mode=1 → seg_out=0x40 while dig_en=0100. Set digit 2=7 → 0x07.
- Blank and error: blank=0b0100 → the digit-2 slot gives seg_out=0 and dig_en=0 while other digits are unaffected. Write with wr_addr=5 and NUM_DIGITS=4 → wr_err pulses one cycle and storage is unchanged.
- Boundaries:
  - Change div_load from 100 to 2 while cnt=50 → the tick occurs on the next edge, with no wrap-around stall.
  - Write to the digit being scanned on the tick edge → the new value is shown when that digit is next selected.
  - Assert reset_n low mid-scan → outputs are 0 immediately.
